mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-side bus to two async SRAM banks and a byte UART, one access at a time.
// Define MEM_BUS_UART_EN to map the UART at 0xBFD003F8/0xBFD003FC; otherwise those addresses fault.
module mem_bus_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_ADDR_W  = 20,
    parameter int BANK_BIT    = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic [1:0]            size,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    inout  wire  [31:0]           base_ram_data,
    output logic [RAM_ADDR_W-1:0] base_ram_addr,
    output logic [3:0]            base_ram_be_n,
    output logic                  base_ram_ce_n,
    output logic                  base_ram_oe_n,
    output logic                  base_ram_we_n,
    inout  wire  [31:0]           ext_ram_data,
    output logic [RAM_ADDR_W-1:0] ext_ram_addr,
    output logic [3:0]            ext_ram_be_n,
    output logic                  ext_ram_ce_n,
    output logic                  ext_ram_oe_n,
    output logic                  ext_ram_we_n,
    output logic                  uart_rdn,
    output logic                  uart_wrn,
    input  logic                  uart_dataready,
    input  logic                  uart_tbre,
    input  logic                  uart_tsre
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    typedef enum logic [2:0] {T_BASE, T_EXT, T_UDATA, T_USTAT, T_ERR} tgt_t;

    state_t                state;
    tgt_t                  tgt, dec;
    logic [3:0]            cnt, be_n, be_new;
    logic [31:0]           dout, st_data, ld_raw, ld_val;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [1:0]            lsize, loff;
    logic                  lwe, ce_n, oe_n, we_n, drive;
    logic                  is_ram, misal, hit_d, hit_s, ram_t, sel_b, sel_e;

`ifdef MEM_BUS_UART_EN
    assign hit_d = addr == 32'hBFD0_03F8;
    assign hit_s = addr == 32'hBFD0_03FC;
`else
    assign hit_d = 1'b0;
    assign hit_s = 1'b0;
`endif

    always_comb begin
        is_ram  = addr[31:23] == 9'h100;
        misal   = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        dec     = misal ? T_ERR : is_ram ? (addr[BANK_BIT] ? T_EXT : T_BASE) :
                  hit_d ? T_UDATA : hit_s ? T_USTAT : T_ERR;
        be_new  = size == 2'b00 ? ~(4'b0001 << addr[1:0]) :
                  size == 2'b01 ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b0000;
        st_data = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
        ld_raw  = tgt == T_EXT ? ext_ram_data : base_ram_data;
        ld_val  = tgt == T_USTAT ? {30'b0, uart_dataready, uart_tbre & uart_tsre} :
                  tgt == T_UDATA ? {24'b0, ld_raw[7:0]} :
                  lsize == 2'b00 ? {{24{ld_raw[{loff, 3'b000} + 7]}}, ld_raw[{loff, 3'b000} +: 8]} :
                  lsize == 2'b01 ? {{16{ld_raw[{loff[1], 4'b0000} + 15]}}, ld_raw[{loff[1], 4'b0000} +: 16]} :
                  ld_raw;
    end

    // Strobes live in one shared register set and are steered to the latched bank only.
    assign ram_t         = tgt == T_BASE || tgt == T_EXT;
    assign sel_b         = tgt == T_BASE;
    assign sel_e         = tgt == T_EXT;
    assign base_ram_addr = ram_addr;
    assign ext_ram_addr  = ram_addr;
    assign base_ram_ce_n = ce_n | ~sel_b;
    assign base_ram_oe_n = oe_n | ~sel_b;
    assign base_ram_we_n = we_n | ~sel_b;
    assign base_ram_be_n = (sel_b && !ce_n) ? be_n : 4'hF;
    assign ext_ram_ce_n  = ce_n | ~sel_e;
    assign ext_ram_oe_n  = oe_n | ~sel_e;
    assign ext_ram_we_n  = we_n | ~sel_e;
    assign ext_ram_be_n  = (sel_e && !ce_n) ? be_n : 4'hF;
    assign base_ram_data = (drive && (sel_b || tgt == T_UDATA)) ? dout : 32'bz;
    assign ext_ram_data  = (drive && sel_e) ? dout : 32'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt      <= T_ERR;
            cnt      <= 4'd0;
            lwe      <= 1'b0;
            lsize    <= 2'b00;
            loff     <= 2'b00;
            ram_addr <= '0;
            be_n     <= 4'hF;
            dout     <= 32'h0;
            ce_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            uart_rdn <= 1'b1;
            uart_wrn <= 1'b1;
            drive    <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    tgt      <= dec;
                    lwe      <= we;
                    lsize    <= size;
                    loff     <= addr[1:0];
                    ram_addr <= addr[RAM_ADDR_W+1:2];
                    be_n     <= be_new;
                    dout     <= st_data;
                    if (dec == T_ERR) begin
                        state <= DONE;
                        ready <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state <= SETUP;
                        ce_n  <= !(dec == T_BASE || dec == T_EXT);
                    end
                end
                // A UART write waits here until the transmitter buffer is free.
                SETUP: if (!(tgt == T_UDATA && lwe && !uart_tbre)) begin
                    state    <= ACCESS;
                    cnt      <= 4'(WAIT_CYCLES - 1);
                    oe_n     <= lwe | ~ram_t;
                    we_n     <= ~lwe | ~ram_t;
                    uart_rdn <= lwe | (tgt != T_UDATA);
                    uart_wrn <= ~lwe | (tgt != T_UDATA);
                    drive    <= lwe & (ram_t | (tgt == T_UDATA));
                end
                ACCESS: if (cnt == 4'd0) begin
                    state    <= DONE;
                    ready    <= 1'b1;
                    ce_n     <= 1'b1;
                    oe_n     <= 1'b1;
                    we_n     <= 1'b1;
                    uart_rdn <= 1'b1;
                    uart_wrn <= 1'b1;
                    drive    <= 1'b0;
                    if (!lwe) rdata <= ld_val;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
